// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl: multicycle sequencer driving the register-file control and
// address ports through READ -> EXEC -> WB -> PC for one instruction at a time.
// Optional feature macro: REG_SEQ_RETIRE_CNT_EN adds the 32-bit `retired`
// counter port.
//
// state | meaning
// IDLE  | waiting for an instruction, instr_ready high
// READ  | operand addresses presented, PC read requested
// EXEC  | ALU running, waits for exec_done or timeout
// WB    | result write-back (strobe only when op_wr)
// PC    | PC update, done pulse
module reg_seq_ctrl #(
  parameter int EXEC_TIMEOUT = 16,
  parameter int PC_STEP      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  op_rn,
  input  logic [3:0]  op_rm,
  input  logic [3:0]  op_rd,
  input  logic        op_wr,
  input  logic        op_branch,
  input  logic [31:0] branch_target,
  input  logic [31:0] pc_in,
  output logic        exec_start,
  input  logic        exec_done,
  output logic        rf_enable,
  output logic        rf_rwA,
  output logic        rf_rwB,
  output logic        rf_rwPc,
  output logic        rf_rwResult,
  output logic        rf_getPc,
  output logic [3:0]  rf_addressA,
  output logic [3:0]  rf_addressB,
  output logic [3:0]  rf_addressResult,
  output logic [31:0] rf_dataInPc,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef REG_SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_PC   = 3'd4
  } state_t;

  localparam logic [7:0]  TIMEOUT_LAST = 8'(EXEC_TIMEOUT - 1);
  localparam logic [31:0] STEP         = 32'(PC_STEP);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  rn_q;
  logic [3:0]  rm_q;
  logic [3:0]  rd_q;
  logic        wr_q;
  logic        br_q;
  logic [31:0] tgt_q;
  logic [7:0]  exec_cnt;
  logic        accept;
  logic        timeout_hit;

  assign accept      = instr_valid && (state == S_IDLE);
  // exec_done on the final allowed cycle wins over the timeout
  assign timeout_hit = (state == S_EXEC) && !exec_done && (exec_cnt == TIMEOUT_LAST);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_READ;
      S_READ: state_nxt = S_EXEC;
      S_EXEC: begin
        if (exec_done)        state_nxt = S_WB;
        else if (timeout_hit) state_nxt = S_PC;
      end
      S_WB:    state_nxt = S_PC;
      S_PC:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // instruction capture, held stable until the return to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rn_q  <= '0;
      rm_q  <= '0;
      rd_q  <= '0;
      wr_q  <= 1'b0;
      br_q  <= 1'b0;
      tgt_q <= '0;
    end else if (accept) begin
      rn_q  <= op_rn;
      rm_q  <= op_rm;
      rd_q  <= op_rd;
      wr_q  <= op_wr;
      br_q  <= op_branch;
      tgt_q <= branch_target;
    end
  end

  // EXEC cycle counter; zero on entry since EXEC is only reached from READ
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  exec_cnt <= '0;
    else if (state == S_EXEC) exec_cnt <= exec_cnt + 8'd1;
    else                      exec_cnt <= '0;
  end

  // sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              err <= 1'b0;
    else if (timeout_hit) err <= 1'b1;
  end

`ifdef REG_SEQ_RETIRE_CNT_EN
  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                retired <= '0;
    else if (state == S_PC) retired <= retired + 32'd1;
  end
`endif

  // output decode
  always_comb begin
    instr_ready      = 1'b0;
    exec_start       = 1'b0;
    rf_enable        = 1'b0;
    rf_rwA           = 1'b0;
    rf_rwB           = 1'b0;
    rf_rwPc          = 1'b0;
    rf_rwResult      = 1'b0;
    rf_getPc         = 1'b0;
    rf_addressA      = '0;
    rf_addressB      = '0;
    rf_addressResult = '0;
    rf_dataInPc      = '0;
    busy             = (state != S_IDLE);
    done             = 1'b0;
    if (state != S_IDLE) begin
      rf_addressA      = rn_q;
      rf_addressB      = rm_q;
      rf_addressResult = rd_q;
    end
    case (state)
      S_IDLE: instr_ready = 1'b1;
      S_READ: rf_getPc = 1'b1;
      S_EXEC: exec_start = (exec_cnt == 8'd0);
      S_WB: begin
        rf_enable   = 1'b1;
        rf_rwResult = wr_q;
      end
      S_PC: begin
        rf_enable   = 1'b1;
        rf_rwPc     = 1'b1;
        done        = 1'b1;
        rf_dataInPc = br_q ? tgt_q : (pc_in + STEP);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Directed self-checking bench for reg_seq_ctrl (EXEC_TIMEOUT=16, PC_STEP=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reg_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  op_rn = '0;
  logic [3:0]  op_rm = '0;
  logic [3:0]  op_rd = '0;
  logic        op_wr = 1'b0;
  logic        op_branch = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc_in = '0;
  logic        exec_start;
  logic        exec_done = 1'b0;
  logic        rf_enable, rf_rwA, rf_rwB, rf_rwPc, rf_rwResult, rf_getPc;
  logic [3:0]  rf_addressA, rf_addressB, rf_addressResult;
  logic [31:0] rf_dataInPc;
  logic        busy, done, err;
`ifdef REG_SEQ_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_seq_ctrl #(.EXEC_TIMEOUT(16), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op_rn(op_rn), .op_rm(op_rm), .op_rd(op_rd),
    .op_wr(op_wr), .op_branch(op_branch), .branch_target(branch_target),
    .pc_in(pc_in),
    .exec_start(exec_start), .exec_done(exec_done),
    .rf_enable(rf_enable), .rf_rwA(rf_rwA), .rf_rwB(rf_rwB),
    .rf_rwPc(rf_rwPc), .rf_rwResult(rf_rwResult), .rf_getPc(rf_getPc),
    .rf_addressA(rf_addressA), .rf_addressB(rf_addressB),
    .rf_addressResult(rf_addressResult), .rf_dataInPc(rf_dataInPc),
    .busy(busy), .done(done), .err(err)
`ifdef REG_SEQ_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Offer one instruction in IDLE; returns at the negedge inside READ with
  // the input fields scrambled so only captured values can reach the outputs.
  task automatic issue(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                       input logic wr, input logic br, input logic [31:0] tgt);
    op_rn = rn; op_rm = rm; op_rd = rd; op_wr = wr; op_branch = br; branch_target = tgt;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    op_rn = ~rn; op_rm = ~rm; op_rd = ~rd; op_wr = ~wr; op_branch = ~br;
    branch_target = 32'hDEAD_BEEF;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, instr_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_en"}, rf_enable, 0);
    chk({tag, "_addrA"}, rf_addressA, 0);
    chk({tag, "_addrR"}, rf_addressResult, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dpc"}, rf_dataInPc, 0);
  endtask

  // READ -> EXEC(done at once) -> WB -> PC -> IDLE, checking WB and PC outputs
  task automatic run_fast(input string tag, input logic [3:0] rd, input logic wr_exp,
                          input logic [31:0] pc, input logic [31:0] pc_exp);
    pc_in = pc;
    @(negedge clk);
    chk({tag, "_start"}, exec_start, 1);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    chk({tag, "_wb_en"}, rf_enable, 1);
    chk({tag, "_wb_rwres"}, rf_rwResult, wr_exp);
    chk({tag, "_wb_addrR"}, rf_addressResult, rd);
    chk({tag, "_wb_rwpc"}, rf_rwPc, 0);
    @(negedge clk);
    chk({tag, "_pc_rwpc"}, rf_rwPc, 1);
    chk({tag, "_pc_data"}, rf_dataInPc, pc_exp);
    chk({tag, "_pc_done"}, done, 1);
    @(negedge clk);
    chk({tag, "_ready"}, instr_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(negedge clk);
    @(negedge clk);
    check_idle("rst");
    chk("rst_err", err, 0);
    chk("rst_rwA", rf_rwA, 0);
    chk("rst_start", exec_start, 0);
`ifdef REG_SEQ_RETIRE_CNT_EN
    chk("rst_retired", retired, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // basic op
    issue(4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 32'h0);
    chk("basic_getpc", rf_getPc, 1);
    chk("basic_addrA", rf_addressA, 1);
    chk("basic_addrB", rf_addressB, 2);
    chk("basic_notready", instr_ready, 0);
    run_fast("basic", 4'd3, 1'b1, 32'h100, 32'h104);
    check_idle("basic_idle");

    // branch, no write
    issue(4'd4, 4'd5, 4'd6, 1'b0, 1'b1, 32'h2000);
    run_fast("branch", 4'd6, 1'b0, 32'h300, 32'h2000);

    // PC wrap
    issue(4'd7, 4'd8, 4'd9, 1'b1, 1'b0, 32'h0);
    run_fast("wrap", 4'd9, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000);

    // exec_done in the 16th EXEC cycle beats the timeout
    issue(4'd1, 4'd1, 4'd2, 1'b1, 1'b0, 32'h0);
    pc_in = 32'h40;
    @(negedge clk);
    for (int i = 1; i < 16; i++) @(negedge clk);
    chk("late_still_exec", rf_enable, 0);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    chk("late_wb_en", rf_enable, 1);
    chk("late_wb_rwpc", rf_rwPc, 0);
    chk("late_err", err, 0);
    @(negedge clk);
    chk("late_pc_data", rf_dataInPc, 32'h44);
    @(negedge clk);

    // timeout
    issue(4'd2, 4'd3, 4'd4, 1'b1, 1'b0, 32'h0);
    pc_in = 32'h80;
    @(negedge clk);
    n = 0;
    while (busy && !rf_enable && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_exec_cycles", n, 16);
    chk("to_skip_wb", rf_rwPc, 1);
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_data", rf_dataInPc, 32'h84);
    @(negedge clk);
    chk("to_idle", instr_ready, 1);
    issue(4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 32'h0);
    run_fast("after_to", 4'd3, 1'b0, 32'h10, 32'h14);
    chk("to_err_sticky", err, 1);

    // reset in the 2nd EXEC cycle
    issue(4'd5, 4'd6, 4'd7, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("midrst");
    chk("midrst_err", err, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      if (rf_rwPc) n++;
    end
    chk("midrst_no_pcw", n, 0);
    issue(4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 32'h0);
    run_fast("post_rst", 4'd3, 1'b1, 32'h200, 32'h204);

    // back-to-back with instr_valid held and exec_done stuck high
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exec_done = 1'b1;
    instr_valid = 1'b1;
    op_rn = 4'd1; op_rm = 4'd2; op_rd = 4'd3; op_wr = 1'b1; op_branch = 1'b0;
    pc_in = 32'h0;
    for (int t = 1; t <= 15; t++) begin
      if (t == 15) instr_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b_start_%0d", t), exec_start, (t % 5 == 2) ? 1 : 0);
      chk($sformatf("b2b_ready_%0d", t), instr_ready, (t % 5 == 0) ? 1 : 0);
      chk($sformatf("b2b_done_%0d", t), done, (t % 5 == 4) ? 1 : 0);
    end
    instr_valid = 1'b0;
    exec_done = 1'b0;
    @(negedge clk);
    chk("b2b_no_4th", busy, 0);
`ifdef REG_SEQ_RETIRE_CNT_EN
    chk("retired", retired, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_seq_ctrl.md
# reg_seq_ctrl

Multicycle sequencer for the processor register file. It accepts one decoded instruction at a time and drives the register-file control and address ports through four phases: operand read, ALU execute, result write-back and PC update. It sits between the decode stage and the register file/ALU pair, and it is the only block that drives the register file's enable, write-strobe and address inputs.

## Interface
Parameters:
- EXEC_TIMEOUT, 16: maximum number of cycles spent in EXEC waiting for exec_done; legal range 1..255.
- PC_STEP, 4: PC increment for non-branch instructions.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  decoded instruction offered.
- instr_ready  out  1  sequencer can accept an instruction; high only in IDLE.
- op_rn  in  4  operand A register index.
- op_rm  in  4  operand B register index.
- op_rd  in  4  destination register index.
- op_wr  in  1  instruction writes op_rd.
- op_branch  in  1  PC loads branch_target instead of incrementing.
- branch_target  in  32  branch destination.
- pc_in  in  32  register-file Pcout.
- exec_start  out  1  one-cycle ALU start pulse.
- exec_done  in  1  ALU result valid on resultIn.
- rf_enable, rf_rwA, rf_rwB, rf_rwPc, rf_rwResult, rf_getPc  out  1 each  register-file controls.
- rf_addressA, rf_addressB, rf_addressResult  out  4 each  register-file addresses.
- rf_dataInPc  out  32  next PC value.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse in the PC state.
- err  out  1  sticky exec-timeout flag; cleared only by rst.
- retired  out  32  count of completed instructions (only with REG_SEQ_RETIRE_CNT_EN).

## Operation
- States: IDLE, READ, EXEC, WB, PC.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, capture op_* and branch_target, then go to READ. Captured fields stay stable until the block returns to IDLE.
- READ: rf_getPc=1, rf_addressA=op_rn, rf_addressB=op_rm, rf_addressResult=op_rd. The register file latches outputs on the falling clock edge. Go to EXEC.
- EXEC: exec_start=1 only in the first EXEC cycle. The timeout counter starts at 0 and increments each EXEC cycle.
  - exec_done=1 moves to WB.
  - If the counter reaches EXEC_TIMEOUT-1 without exec_done, set err and go to PC, skipping WB.
- WB: rf_enable=1, rf_rwResult=op_wr. Go to PC.
- PC: rf_enable=1, rf_rwPc=1, done=1. rf_dataInPc = op_branch ? branch_target : pc_in+PC_STEP, with the sum truncated to 32 bits (wraps). Go to IDLE.
- rf_rwA and rf_rwB are constant 0.
- Addresses are held during READ..PC and are 0 in IDLE. All other control outputs are 0 outside the states listed above.
- exec_done outside EXEC is ignored.
- instr_valid while busy is ignored. The instruction is not captured, and the requester must hold it.

## Timing
- Reset (async assert): state=IDLE. All outputs are 0 except instr_ready=1. err=0, retired=0, timeout counter=0.
- Reset asserted mid-instruction aborts that instruction with no further register-file writes.
- Minimum occupancy is 4 cycles:
  - acceptance edge at cycle 0;
  - READ in cycle 1, EXEC in cycle 2 (exec_done same cycle), WB in cycle 3, PC in cycle 4;
  - instr_ready high again in cycle 5.
- Back-to-back throughput is one instruction per 5 cycles.
- A timed-out instruction occupies 1 + EXEC_TIMEOUT + 1 cycles.
- exec_done arriving in the same cycle the timeout would fire counts as done: no err, and the block goes to WB.
- pc_in is sampled in the PC state and must reflect rf_getPc from READ.

## Configuration
- REG_SEQ_RETIRE_CNT_EN defined:
  - retired is a 32-bit counter that increments on every PC state, including timed-out instructions, and wraps from 0xFFFFFFFF to 0.
  - The counter is cleared by rst.
- REG_SEQ_RETIRE_CNT_EN undefined: the retired port and its counter are absent.

## Test plan
- Basic op: rst, then op_rn=1, op_rm=2, op_rd=3, op_wr=1, pc_in=0x100, exec_done in the first EXEC cycle.
  - Expect rf_rwResult=1 with rf_addressResult=3 in cycle 3.
  - Expect rf_rwPc=1 with rf_dataInPc=0x104 and done=1 in cycle 4.
  - Expect instr_ready=1 in cycle 5.
- Branch with no write: op_branch=1, branch_target=0x2000, op_wr=0.
  - Expect rf_rwResult=0 in WB.
  - Expect rf_dataInPc=0x2000.
- PC wrap: pc_in=0xFFFFFFFC, op_branch=0 gives rf_dataInPc=0x00000000.
- Timeout: EXEC_TIMEOUT=16, exec_done never asserted.
  - Expect 16 EXEC cycles, no WB, then PC with done=1.
  - Expect err=1, held until rst.
  - Repeat with exec_done in the 16th EXEC cycle: expect WB and err=0.
- Reset mid-EXEC: assert rst in the 2nd EXEC cycle.
  - Expect all outputs 0 immediately (instr_ready=1), with no rf_rwPc pulse.
  - Expect the next instruction to sequence normally.
- Handshake and counter: hold instr_valid high across 3 instructions with exec_done stuck high.
  - Expect acceptances at cycles 0, 5, 10 and exec_start pulses of exactly one cycle.
  - With REG_SEQ_RETIRE_CNT_EN defined, expect retired=3.
